// File: rtl/sfifo_param_if.sv
// sfifo_param_if: producer/consumer bundle for sfifo_param (write, read, status).
`default_nettype none

interface sfifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              w_en;
  logic [DATA_W-1:0] din;
  logic              r_en;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output w_en, din, r_en,
    input  dout, dout_vld, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, din, r_en,
    output dout, dout_vld, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/sfifo_param.sv
// +----------------------------------------------------------------------------+
// | sfifo_param: parametrised single-clock FIFO with count, thresholds and      |
// | per-cycle overflow/underflow pulses. Define SFIFO_FWFT_EN for FWFT output.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sfifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AFULL_TH  = (2**ADDR_W) - 4,
  parameter int AEMPTY_TH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  sfifo_param_if.slave  bus
);
  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_AFULL   = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] c_AEMPTY  = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_afull;
  logic              r_aempty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [ADDR_W:0]   w_count_next;

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_rd_acc     = bus.r_en && !r_empty;
  assign w_wr_acc     = bus.w_en && (!r_full || w_rd_acc);
  assign w_count_next = r_count + (ADDR_W+1)'(w_wr_acc) - (ADDR_W+1)'(w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == c_DEPTH);
      r_empty     <= (w_count_next == '0);
      r_afull     <= (w_count_next >= c_AFULL);
      r_aempty    <= (w_count_next <= c_AEMPTY);
      r_overflow  <= bus.w_en && !w_wr_acc;
      r_underflow <= bus.r_en && !w_rd_acc;
    end
  end

`ifdef SFIFO_FWFT_EN
  // Head word is presented directly; r_en only pops it.
  assign bus.dout     = r_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.dout_vld = !r_empty;
`else
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
`endif

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire
